kb_fifo_reader: RTL



---
 rtl/kb_fifo_reader.sv | 98 +++++++++
 1 files changed

// File: rtl/kb_fifo_reader.sv
// kb_fifo_reader: read side of the keyboard FIFO.
// Pops one ASCII code at a time from a FIFO with one-cycle read latency. Each
// code is shown to the CPU on KB_IN/KB_CH until KB_EN consumes it, or until it
// has waited STALE_CYCLES cycles and is discarded. Discards are counted in a
// saturating counter.
// Optional build macro: KB_WASD_FILTER_EN. When it is defined, only W/A/S/D
// codes are presented and every other code is dropped and counted.
module kb_fifo_reader #(
    parameter logic [23:0] STALE_CYCLES = 24'd5_000_000,
    parameter int          CNT_W        = 8
) (
    input  logic             FPGA_GlobalClock,
    input  logic             FPGA_GlobalReset_n,
    input  logic             fifo_empty,
    input  logic [6:0]       fifo_dout,
    output logic             fifo_rd_en,
    output logic             KB_IN,
    output logic [6:0]       KB_CH,
    input  logic             KB_EN,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, READ, CAPTURE, PRESENT} state_t;

    state_t             state_q, state_d;
    logic [6:0]         ch_q;
    logic [23:0]        stale_q;
    logic [CNT_W-1:0]   drop_q;
    logic               accept;
    logic               timeout_hit;
    logic               drop_inc;

`ifdef KB_WASD_FILTER_EN
    // Only the four movement keys are useful to the game.
    assign accept = (fifo_dout == 7'h57) || (fifo_dout == 7'h41) ||
                    (fifo_dout == 7'h53) || (fifo_dout == 7'h44);
`else
    assign accept = 1'b1;
`endif

    // A value of zero for STALE_CYCLES turns the timeout off.
    assign timeout_hit = (STALE_CYCLES != 24'd0) &&
                         (stale_q == STALE_CYCLES - 24'd1);

    // State register.
    always_ff @(posedge FPGA_GlobalClock) begin
        if (!FPGA_GlobalReset_n) state_q <= IDLE;
        else                     state_q <= state_d;
    end

    // Next-state logic. KB_EN takes priority over the timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = READ;
            READ:    state_d = CAPTURE;
            CAPTURE: state_d = accept ? PRESENT : IDLE;
            PRESENT: begin
                if (KB_EN)            state_d = fifo_empty ? IDLE : READ;
                else if (timeout_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs. The pop strobe is gated with reset, so no pop can be
    // issued in a cycle where reset is sampled low.
    always_comb begin
        fifo_rd_en = (state_q == READ) && FPGA_GlobalReset_n;
        KB_IN      = (state_q == PRESENT);
        busy       = (state_q != IDLE);
        drop_inc   = ((state_q == CAPTURE) && !accept) ||
                     ((state_q == PRESENT) && !KB_EN && timeout_hit);
    end

    // Datapath: the captured character, the wait counter and the drop counter.
    always_ff @(posedge FPGA_GlobalClock) begin
        if (!FPGA_GlobalReset_n) begin
            ch_q    <= 7'h00;
            stale_q <= 24'd0;
            drop_q  <= '0;
        end else begin
            if (state_q == CAPTURE) begin
                ch_q    <= fifo_dout;
                stale_q <= 24'd0;
            end else if (state_q == PRESENT) begin
                stale_q <= stale_q + 24'd1;
            end
            if (drop_inc && (drop_q != {CNT_W{1'b1}}))
                drop_q <= drop_q + CNT_W'(1);
        end
    end

    assign KB_CH    = ch_q;
    assign drop_cnt = drop_q;

endmodule
